// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_state_t : fetch FSM encoding
//   fetch_entry_t : one instruction buffer entry {pc, inst}
//   clog2()       : pointer width helper for the instruction buffer
//   NOP           : canonical no-op word (addi x0,x0,0), handy for benches
package fetch_pkg;

  localparam int unsigned INST_W  = 32;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Bundle of the fetch stage's memory, decode and redirect signals.
//   master : fetch stage view (drives imem request and decode stream)
//   slave  : environment view (memory, decode and execute stages)
interface inst_fetch_if;
  import fetch_pkg::*;

  logic              o_imem_req;
  logic [31:0]       o_imem_addr;
  logic              i_imem_ack;
  logic [INST_W-1:0] i_imem_rdata;
  logic [INST_W-1:0] o_inst_data;
  logic [31:0]       o_inst_pc;
  logic              o_inst_valid;
  logic              i_inst_ready;
  logic              i_redirect;
  logic [31:0]       i_redirect_pc;

  modport master (
    output o_imem_req, o_imem_addr,
    input  i_imem_ack, i_imem_rdata,
    output o_inst_data, o_inst_pc, o_inst_valid,
    input  i_inst_ready,
    input  i_redirect, i_redirect_pc
  );

  modport slave (
    input  o_imem_req, o_imem_addr,
    output i_imem_ack, i_imem_rdata,
    input  o_inst_data, o_inst_pc, o_inst_valid,
    output i_inst_ready,
    output i_redirect, i_redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer of {pc, inst} entries.
//   i_clk/i_rst : clock, synchronous active-high reset
//   push/data   : write entry (ignored when full)
//   pop         : drop head entry (ignored when empty)
//   flush       : empty the buffer; wins over push and pop
//   head        : current head entry (stale when empty)
//   full/empty/count : occupancy status
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  localparam int unsigned PTR_W     = clog2(FIFO_DEPTH)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         push,
  input  fetch_entry_t data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [PTR_W:0] count
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

  fetch_entry_t     mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   cnt;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full    = (cnt == DEPTH_CNT);
    empty   = (cnt == '0);
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    head    = mem[rd_ptr];
    count   = cnt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (PTR_W+1)'(1);
        2'b01:   cnt <= cnt - (PTR_W+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push && !flush) mem[wr_ptr] <= data;
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: keeps the fetch PC, issues single-outstanding
// word reads to instruction memory, buffers returned words with their PC
// and hands them to decode over valid/ready. A redirect flushes the
// buffer and restarts fetch at the new PC, draining any in-flight read.
//   i_clk/i_rst : clock, synchronous active-high reset
//   bus         : imem req/addr/ack/rdata, decode data/pc/valid/ready,
//                 redirect/redirect_pc (master view)
module inst_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic   i_clk,
  input  logic   i_rst,
  inst_fetch_if.master bus
);

  localparam int unsigned CNT_W = clog2(FIFO_DEPTH) + 1;

  fetch_state_t     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      redir_pc_q, redir_pc_d;
  logic [31:0]      redirect_pc_al;
  logic             push, pop;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count, count_after_pop;
  logic             slot_free, slot_after_push;
  fetch_entry_t     push_entry, head_entry;

  fetch_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .push  (push & ~fifo_full),
    .data  (push_entry),
    .pop   (pop),
    .flush (bus.i_redirect),
    .head  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    redirect_pc_al  = {bus.i_redirect_pc[31:2], 2'b00};
    pop             = ~fifo_empty & bus.i_inst_ready;
    count_after_pop = fifo_count - {{(CNT_W-1){1'b0}}, pop};
    slot_free       = count_after_pop < CNT_W'(FIFO_DEPTH);
    slot_after_push = count_after_pop < CNT_W'(FIFO_DEPTH - 1);
    push_entry.pc   = pc_q;
    push_entry.inst = bus.i_imem_rdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      redir_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  // pc_q doubles as the request address, so in S_DRAIN it stays on the
  // abandoned address while the redirect target waits in redir_pc_q.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redir_pc_d = redir_pc_q;
    push       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_redirect) begin
          state_d = S_FETCH;
          pc_d    = redirect_pc_al;
        end else if (slot_free) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus.i_redirect) begin
          if (bus.i_imem_ack) begin
            state_d = S_FETCH;
            pc_d    = redirect_pc_al;
          end else begin
            state_d    = S_DRAIN;
            redir_pc_d = redirect_pc_al;
          end
        end else if (bus.i_imem_ack) begin
          push    = 1'b1;
          pc_d    = pc_q + PC_STEP;
          state_d = slot_after_push ? S_FETCH : S_IDLE;
        end
      end
      S_DRAIN: begin
        // A redirect landing on the draining ack retargets straight away
        // rather than reissuing the dead address.
        if (bus.i_imem_ack) begin
          state_d = S_FETCH;
          pc_d    = bus.i_redirect ? redirect_pc_al : redir_pc_q;
        end else if (bus.i_redirect) begin
          redir_pc_d = redirect_pc_al;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.o_imem_req   = (state_q != S_IDLE);
    bus.o_imem_addr  = pc_q;
    bus.o_inst_valid = ~fifo_empty;
    bus.o_inst_data  = fifo_empty ? '0 : head_entry.inst;
    bus.o_inst_pc    = fifo_empty ? '0 : head_entry.pc;
  end

endmodule
